// File: rtl/counter_pkg.sv
// Shared types for the counting primitives: terminal-behaviour modes and run/done state.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP     = 2'd0,
    SATURATE = 2'd1,
    ONESHOT  = 2'd2,
    RSVD     = 2'd3
  } mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage : counter_pkg

// File: rtl/mode_counter.sv
// Parametrised up/down counter with parallel load and wrap / saturate / one-shot terminals.
// Flags are registered pulses; at_max/at_min/done decode straight from registered state.
module mode_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped,
  output logic             done,
  output logic             load_err
);

  if (WIDTH < 2) begin : g_bad_width
    $fatal(1, "mode_counter: WIDTH must be >= 2");
  end
  if ((MAX_VALUE < 1) || (longint'(MAX_VALUE) > ((longint'(1) << WIDTH) - 1))) begin : g_bad_max
    $fatal(1, "mode_counter: MAX_VALUE must lie in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH:0]   MAX_XC = (WIDTH+1)'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0]   step_w;
  logic             at_term;
  logic             landed;
  mode_t            mode_m;

  // Next-state: load beats enable; terminal behaviour chosen by the sampled mode.
  always_comb begin
    count_d    = count_q;
    state_d    = state_q;
    wrapped_d  = 1'b0;
    load_err_d = 1'b0;
    mode_m     = mode_t'(mode);
    step_w     = up_dn ? ({1'b0, count_q} + (WIDTH+1)'(1))
                       : ({1'b0, count_q} - (WIDTH+1)'(1));
    at_term    = up_dn ? (count_q == MAX_C) : (count_q == '0);
    landed     = up_dn ? (step_w == MAX_XC) : (step_w == '0);

    if (load) begin
      count_d    = (load_value > MAX_C) ? MAX_C : load_value;
      load_err_d = (load_value > MAX_C);
      state_d    = RUN;
    end else if (en && (state_q == RUN)) begin
      if (at_term) begin
        case (mode_m)
          SATURATE: count_d = count_q;
          ONESHOT:  state_d = DONE;
          default: begin
            count_d   = up_dn ? '0 : MAX_C;
            wrapped_d = 1'b1;
          end
        endcase
      end else begin
        count_d = step_w[WIDTH-1:0];
        if ((mode_m == ONESHOT) && landed) begin
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      state_q    <= RUN;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      state_q    <= state_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign at_max   = (count_q == MAX_C);
  assign at_min   = (count_q == '0);
  assign wrapped  = wrapped_q;
  assign done     = (state_q == DONE);
  assign load_err = load_err_q;

endmodule : mode_counter

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter (WIDTH=4, MAX_VALUE=8): a behavioural model queues
// the expected outputs per driven cycle, each test pairs them with what the DUT showed.
module tb_mode_counter;

  localparam int MAXV = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic       at_max, at_min, wrapped, done, load_err;

  mode_counter #(.WIDTH(4), .MAX_VALUE(MAXV)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .mode(mode),
    .load(load), .load_value(load_value), .count(count), .at_max(at_max),
    .at_min(at_min), .wrapped(wrapped), .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {count, at_max, at_min, wrapped, done, load_err}
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  int m_cnt  = 0;
  bit m_done = 1'b0;
  bit m_wr   = 1'b0;
  bit m_le   = 1'b0;

  function automatic logic [8:0] model_vec();
    logic [3:0] c;
    c = 4'(m_cnt);
    return {c, (m_cnt == MAXV), (m_cnt == 0), m_wr, m_done, m_le};
  endfunction

  // Behavioural reference: what one clock edge should do to the counter.
  task automatic model(input bit r, input bit ld, input int lv, input bit e,
                       input bit ud, input int md);
    m_wr = 1'b0;
    m_le = 1'b0;
    if (!r) begin
      m_cnt = 0; m_done = 1'b0;
    end else if (ld) begin
      m_cnt = (lv > MAXV) ? MAXV : lv;
      m_le = (lv > MAXV);
      m_done = 1'b0;
    end else if (e && !m_done) begin
      if ((ud && m_cnt == MAXV) || (!ud && m_cnt == 0)) begin
        if (md == 2) m_done = 1'b1;
        else if (md != 1) begin
          m_cnt = ud ? 0 : MAXV;
          m_wr = 1'b1;
        end
      end else begin
        m_cnt = ud ? m_cnt + 1 : m_cnt - 1;
        if (md == 2 && ((ud && m_cnt == MAXV) || (!ud && m_cnt == 0))) m_done = 1'b1;
      end
    end
  endtask

  // Drive one cycle, queue expected, capture observed one time unit past the edge.
  task automatic step(input bit r, input bit ld, input int lv, input bit e,
                      input bit ud, input int md);
    reset = r; load = ld; load_value = 4'(lv); en = e; up_dn = ud; mode = 2'(md);
    model(r, ld, lv, e, ud, md);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    obs_q.push_back({count, at_max, at_min, wrapped, done, load_err});
  endtask

  task automatic test_reset();
    logic [8:0] e, o;
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 5, 1, 1, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset: got %b want %b", o, e); end
    end
    checks++;
    if ({count, at_min} !== 5'b0000_1) begin
      errors++; $display("FAIL reset_const: got count=%0d at_min=%b want 0/1", count, at_min);
    end
  endtask

  task automatic test_wrap_up();
    logic [8:0] e, o;
    int wraps = 0, maxes = 0;
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1, 1, 0);
      if (wrapped) wraps++;
      if (at_max) maxes++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_up: got %b want %b", o, e); end
    end
    checks++;
    if (wraps !== 1 || maxes !== 1 || count !== 4'd1) begin
      errors++;
      $display("FAIL wrap_up_pulses: got wraps=%0d maxes=%0d count=%0d want 1/1/1", wraps, maxes, count);
    end
  endtask

  task automatic test_wrap_down();
    logic [8:0] e, o;
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    checks++;
    if (count !== 4'd8 || wrapped !== 1'b1) begin
      errors++; $display("FAIL wrap_down_first: got count=%0d wrapped=%b want 8/1", count, wrapped);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 3);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_down: got %b want %b", o, e); end
    end
  endtask

  task automatic test_saturate();
    logic [8:0] e, o;
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL saturate: got %b want %b", o, e); end
    end
  endtask

  task automatic test_oneshot();
    logic [8:0] e, o;
    step(0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 2);
    checks++;
    if (count !== 4'd8 || done !== 1'b1) begin
      errors++; $display("FAIL oneshot_hold: got count=%0d done=%b want 8/1", count, done);
    end
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 3, 1, 1, 2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 2);
    step(1, 1, 8, 0, 1, 2);
    step(1, 0, 0, 1, 1, 2);
    step(1, 1, 1, 0, 0, 2);
    step(1, 0, 0, 1, 0, 2);
    step(1, 0, 0, 1, 1, 2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL oneshot: got %b want %b", o, e); end
    end
  endtask

  task automatic test_load();
    logic [8:0] e, o;
    step(1, 1, 13, 0, 1, 0);
    checks++;
    if (count !== 4'd8 || load_err !== 1'b1) begin
      errors++; $display("FAIL load_clamp: got count=%0d load_err=%b want 8/1", count, load_err);
    end
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 2, 1, 1, 0);
    step(1, 1, 8, 1, 0, 0);
    step(1, 1, 15, 1, 0, 1);
    step(1, 1, 9, 1, 1, 0);
    step(1, 0, 0, 1, 1, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL load: got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] e, o;
    step(1, 1, 13, 0, 1, 2);
    step(1, 1, 4, 0, 1, 2);
    step(1, 0, 0, 1, 1, 2);
    step(0, 1, 12, 1, 1, 2);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid: got %b want %b", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] e, o;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 40) != 0), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 5) != 0), int'($urandom_range(0, 3)));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL back_to_back: got %b want %b", o, e); end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; mode = 2'd0; load = 1'b0; load_value = 4'd0;
    #1;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_oneshot();
    test_load();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mode_counter
